// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory pipeline stage.
// Revision: 1.0
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_MEMWRITE = 1;
  localparam int FLAG_MEMREAD  = 0;

  localparam int DEF_TIMEOUT = 255;

  typedef struct packed {
    logic [47:0] pc1;
    logic [2:0]  flags_mem;
    logic [1:0]  flags_wb;
    logic [5:0]  opcode;
    logic [47:0] result;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } payload_t;

  function automatic logic is_mem_op(input logic [2:0] flags);
    return flags[FLAG_MEMWRITE] | flags[FLAG_MEMREAD];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_latch.sv
// mem_stage_latch: EX/MEM payload register with load and clear controls.
// Revision: 1.0
`default_nettype none

module mem_stage_latch
  import mem_stage_pkg::*;
(
  input  logic     clk,
  input  logic     i_load,
  input  logic     i_clear,
  input  payload_t i_d,
  output payload_t o_q
);

  payload_t r_q;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with handshake to a single-port memory.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN. Revision: 1.0
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [47:0]       pc1_in,
  input  logic [2:0]        flagsMEM_in,
  input  logic [1:0]        flagsWB_in,
  input  logic [5:0]        opcode_in,
  input  logic [47:0]       result_in,
  input  logic [47:0]       datainput_in,
  input  logic [4:0]        rd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [1:0]        flagsWB_out,
  output logic [4:0]        rd_out,
  output logic [5:0]        opcode_out,
  output logic [47:0]       pc1_out,
  output logic [47:0]       alu_result_out,
  output logic [31:0]       read_data_out,
  output logic              zero_out,
  output logic              mem_error
);

  state_e   r_state;
  state_e   w_next;
  payload_t w_pl_in;
  payload_t w_pl_q;
  logic     w_accept;
  logic     w_is_mem;
  logic     w_ack;
  logic     w_timeout;
  logic     w_is_load;
  logic     r_flushed;
  logic     r_wb_valid;
  logic [31:0] r_rdata;

  assign w_pl_in = '{pc1: pc1_in, flags_mem: flagsMEM_in, flags_wb: flagsWB_in,
                     opcode: opcode_in, result: result_in,
                     wdata: datainput_in[31:0], rd: rd_in};

  assign w_accept  = in_valid & (r_state == ST_IDLE);
  assign w_is_mem  = is_mem_op(flagsMEM_in);
  assign w_ack     = mem_ack & (r_state == ST_ACCESS);
  // Read+write together behaves as a store, so only a pure read loads data.
  assign w_is_load = w_pl_q.flags_mem[FLAG_MEMREAD] & ~w_pl_q.flags_mem[FLAG_MEMWRITE];

  mem_stage_latch u_latch (
    .clk     (clk),
    .i_load  (w_accept),
    .i_clear (rst),
    .i_d     (w_pl_in),
    .o_q     (w_pl_q)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_mem_error;

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_ACCESS)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) & ~mem_ack & (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_error <= 1'b0;
    end else if (w_timeout) begin
      r_mem_error <= 1'b1;
    end
  end

  assign mem_error = r_mem_error;
  wire w_unused_bits = ^datainput_in[47:32];
`else
  assign w_timeout = 1'b0;
  assign mem_error = 1'b0;
  wire w_unused_bits = ^{datainput_in[47:32], 32'(TIMEOUT)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid && w_is_mem) w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ack)        w_next = ST_IDLE;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    case (r_state)
      ST_IDLE:   in_ready = 1'b1;
      ST_ACCESS: begin
        mem_req = 1'b1;
        mem_we  = w_pl_q.flags_mem[FLAG_MEMWRITE];
      end
      default: ;
    endcase
  end

  // A flush during an access is remembered until the memory answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flushed <= 1'b0;
    end else if (w_accept) begin
      r_flushed <= flush;
    end else if (r_state == ST_ACCESS) begin
      r_flushed <= mem_ack ? 1'b0 : (r_flushed | flush);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && !w_is_mem && !flush) begin
        r_wb_valid <= 1'b1;
      end
      if (w_ack && !r_flushed && !flush) begin
        r_wb_valid <= 1'b1;
        if (w_is_load) begin
          r_rdata <= mem_rdata;
        end
      end
    end
  end

  assign wb_valid       = r_wb_valid;
  assign read_data_out  = r_rdata;
  assign mem_addr       = w_pl_q.result[ADDR_W-1:0];
  assign mem_wdata      = w_pl_q.wdata;
  assign flagsWB_out    = w_pl_q.flags_wb;
  assign rd_out         = w_pl_q.rd;
  assign opcode_out     = w_pl_q.opcode;
  assign pc1_out        = w_pl_q.pc1;
  assign alu_result_out = w_pl_q.result;
  assign zero_out       = w_pl_q.flags_mem[FLAG_ZERO];

endmodule

`default_nettype wire
